// File: rtl/fft8_input_framer_if.sv
// fft8_input_framer_if: stream-in / frame-out bundle for the FFT8 input framer.
//   in_valid/in_ready/in_re/in_im/in_last : serial complex Q8.8 sample stream
//   out_valid/out_ready/out_re/out_im     : one parallel 8-sample frame per beat
//   frame_cnt                             : frames delivered, modulo 2^16
//   frame_err                             : one-cycle framing error pulse
// master = sample source / frame sink side, slave = framer side.
interface fft8_input_framer_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NPT    = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_re;
  logic [DATA_W-1:0]     in_im;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [NPT*DATA_W-1:0] out_re;
  logic [NPT*DATA_W-1:0] out_im;
  logic [15:0]           frame_cnt;
  logic                  frame_err;

  modport master (
    output in_valid, in_re, in_im, in_last, out_ready,
    input  in_ready, out_valid, out_re, out_im, frame_cnt, frame_err
  );

  modport slave (
    input  in_valid, in_re, in_im, in_last, out_ready,
    output in_ready, out_valid, out_re, out_im, frame_cnt, frame_err
  );
endinterface

// File: rtl/fft8_input_framer.sv
// fft8_input_framer: collects serial complex samples into 8-sample frames using
// two ping-pong banks and hands each full frame to the FFT core as one word.
//   clk, rst_n : single clock, synchronous active-low reset
//   bus        : fft8_input_framer_if.slave (sample stream in, frame out,
//                frame_cnt, frame_err)
// Build option: define FFT8_INPUT_BITREV_EN to store samples in bit-reversed
// slot order (out slot k = input sample bitrev3(k)); otherwise natural order.
module fft8_input_framer #(
  parameter int unsigned INT_W  = 8,
  parameter int unsigned FRAC_W = 8,
  parameter int unsigned NPT    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  fft8_input_framer_if.slave  bus
);
  localparam int unsigned DATA_W = INT_W + FRAC_W;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned CNT_W  = 16;

  if (NPT != 8) begin : g_npt_check
    $error("fft8_input_framer: NPT must be 8");
  end

  logic [DATA_W-1:0]     re_mem_q [2][NPT];
  logic [DATA_W-1:0]     im_mem_q [2][NPT];

  logic [IDX_W-1:0]      wr_idx_q, wr_idx_d;
  logic                  wb_q, wb_d;
  logic                  rb_q, rb_d;
  logic [1:0]            full_q, full_d;
  logic                  out_valid_q, out_valid_d;
  logic [NPT*DATA_W-1:0] out_re_q, out_re_d;
  logic [NPT*DATA_W-1:0] out_im_q, out_im_d;
  logic [CNT_W-1:0]      frame_cnt_q, frame_cnt_d;
  logic                  frame_err_q, frame_err_d;

  logic                  in_ready_c;
  logic                  wr_fire_c;
  logic                  rd_fire_c;
  logic                  last_slot_c;
  logic [IDX_W-1:0]      wr_slot_c;

  // Both banks full <=> the bank we would write next is still full.
  assign in_ready_c  = !full_q[wb_q];
  assign wr_fire_c   = bus.in_valid && in_ready_c;
  assign rd_fire_c   = out_valid_q && bus.out_ready;
  assign last_slot_c = (wr_idx_q == IDX_W'(NPT - 1));

`ifdef FFT8_INPUT_BITREV_EN
  // Bit reversal is its own inverse, so writing sample j to slot bitrev(j)
  // leaves slot k holding sample bitrev(k).
  assign wr_slot_c = {wr_idx_q[0], wr_idx_q[1], wr_idx_q[2]};
`else
  assign wr_slot_c = wr_idx_q;
`endif

  // Bank storage; validity is tracked by full_q, so no reset needed.
  always_ff @(posedge clk) begin
    if (wr_fire_c) begin
      re_mem_q[wb_q][wr_slot_c] <= bus.in_re;
      im_mem_q[wb_q][wr_slot_c] <= bus.in_im;
    end
  end

  // Write pointer, bank flags, frame counter and error pulse.
  always_comb begin
    wr_idx_d    = wr_idx_q;
    wb_d        = wb_q;
    rb_d        = rb_q;
    full_d      = full_q;
    frame_cnt_d = frame_cnt_q;
    frame_err_d = 1'b0;
    if (wr_fire_c) begin
      if (last_slot_c) begin
        // Length wins: an 8th sample always closes the frame.
        full_d[wb_q] = 1'b1;
        wb_d         = !wb_q;
        wr_idx_d     = '0;
        frame_err_d  = !bus.in_last;
      end else if (bus.in_last) begin
        wr_idx_d    = '0;
        frame_err_d = 1'b1;
      end else begin
        wr_idx_d = wr_idx_q + IDX_W'(1);
      end
    end
    // Read and write banks always differ when both fire.
    if (rd_fire_c) begin
      full_d[rb_q] = 1'b0;
      rb_d         = !rb_q;
      frame_cnt_d  = frame_cnt_q + CNT_W'(1);
    end
  end

  // Output register: reload from the (next) read bank whenever not stalled.
  // Using full_q rather than full_d keeps a bank whose last sample lands this
  // cycle out of the output until its contents are complete.
  always_comb begin
    out_valid_d = out_valid_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    if (!out_valid_q || bus.out_ready) begin
      out_valid_d = full_q[rb_d];
      if (full_q[rb_d]) begin
        for (int unsigned k = 0; k < NPT; k++) begin
          out_re_d[k*DATA_W +: DATA_W] = re_mem_q[rb_d][IDX_W'(k)];
          out_im_d[k*DATA_W +: DATA_W] = im_mem_q[rb_d][IDX_W'(k)];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_idx_q    <= '0;
      wb_q        <= 1'b0;
      rb_q        <= 1'b0;
      full_q      <= '0;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      frame_cnt_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      wr_idx_q    <= wr_idx_d;
      wb_q        <= wb_d;
      rb_q        <= rb_d;
      full_q      <= full_d;
      out_valid_q <= out_valid_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      frame_cnt_q <= frame_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_re    = out_re_q;
  assign bus.out_im    = out_im_q;
  assign bus.frame_cnt = frame_cnt_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_fft8_input_framer.sv
// tb_fft8_input_framer: directed scenarios plus randomized streaming; a
// negedge monitor compares the DUT against a frame-level reference model.
module tb_fft8_input_framer;
  localparam int unsigned DW  = 16;
  localparam int unsigned NP  = 8;
  localparam int unsigned FW  = NP * DW;

  typedef struct {
    logic [FW-1:0] re;
    logic [FW-1:0] im;
    int            t_done;
  } frame_t;

  logic clk;
  logic rst_n;
  int   ordy_mode;   // 0: out_ready low, 1: high, 2: random
  logic rnd_bit;

  fft8_input_framer_if #(.DATA_W(DW), .NPT(NP)) bus_if ();

  fft8_input_framer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  assign bus_if.out_ready = (ordy_mode == 1) || ((ordy_mode == 2) && rnd_bit);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rnd_bit = ($urandom_range(0, 3) != 0);
  end

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  frame_t        exp_q[$];
  logic [DW-1:0] part_re[$];
  logic [DW-1:0] part_im[$];
  int            delivered = 0;
  int            cyc = 0;
  logic          err_pend = 1'b0;
  logic          exp_rdy, exp_vld;
  logic [FW-1:0] cap_re, cap_im;

  function automatic int slot_src(input int k);
`ifdef FFT8_INPUT_BITREV_EN
    return ((k % 2) * 4) + (((k / 2) % 2) * 2) + ((k / 4) % 2);
`else
    return k;
`endif
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      part_re.delete();
      part_im.delete();
      delivered = 0;
      err_pend  = 1'b0;
    end else begin
      exp_rdy = (exp_q.size() < 2);
      exp_vld = (exp_q.size() > 0) && (exp_q[0].t_done <= cyc - 2);
      chk("in_ready",  FW'(bus_if.in_ready),  FW'(exp_rdy));
      chk("out_valid", FW'(bus_if.out_valid), FW'(exp_vld));
      chk("frame_err", FW'(bus_if.frame_err), FW'(err_pend));
      chk("frame_cnt", FW'(bus_if.frame_cnt), FW'(16'(delivered)));
      if (exp_vld && bus_if.out_valid) begin
        chk("out_re", bus_if.out_re, exp_q[0].re);
        chk("out_im", bus_if.out_im, exp_q[0].im);
      end
      err_pend = 1'b0;
      if (exp_vld && bus_if.out_ready) begin
        cap_re = bus_if.out_re;
        cap_im = bus_if.out_im;
        void'(exp_q.pop_front());
        delivered++;
      end
      if (bus_if.in_valid && exp_rdy) begin
        part_re.push_back(bus_if.in_re);
        part_im.push_back(bus_if.in_im);
        if (part_re.size() == NP) begin
          frame_t f;
          for (int k = 0; k < NP; k++) begin
            f.re[k*DW +: DW] = part_re[slot_src(k)];
            f.im[k*DW +: DW] = part_im[slot_src(k)];
          end
          f.t_done = cyc;
          exp_q.push_back(f);
          err_pend = !bus_if.in_last;
          part_re.delete();
          part_im.delete();
        end else if (bus_if.in_last) begin
          err_pend = 1'b1;
          part_re.delete();
          part_im.delete();
        end
      end
    end
    cyc++;
  end

  // ---------------- driver ----------------
  task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im, input logic last);
    logic acc;
    int   guard;
    guard = 0;
    acc   = 1'b0;
    bus_if.in_valid = 1'b1;
    bus_if.in_re    = re;
    bus_if.in_im    = im;
    bus_if.in_last  = last;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = bus_if.in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: in_ready stuck low, got 0 expected 1");
    end
    bus_if.in_valid = 1'b0;
    bus_if.in_last  = 1'b0;
  endtask

  task automatic single_frame();
    logic [DW-1:0] s_re, s_im;
    for (int k = 0; k < NP; k++) send(16'(k * 256), 16'(-(k * 256)), k == NP - 1);
    @(negedge clk); chk("t2_lat0", FW'(bus_if.out_valid), FW'(1'b0));
    @(negedge clk); chk("t2_lat1", FW'(bus_if.out_valid), FW'(1'b1));
    @(negedge clk); chk("t2_lat2", FW'(bus_if.out_valid), FW'(1'b0));
    chk("t2_cnt", FW'(bus_if.frame_cnt), FW'(16'd1));
`ifdef FFT8_INPUT_BITREV_EN
    s_re = cap_re[1*DW +: DW];
    s_im = cap_im[1*DW +: DW];
    chk("t2_slot1_re", FW'(s_re), FW'(16'h0400));
    chk("t2_slot1_im", FW'(s_im), FW'(16'hFC00));
`else
    s_re = cap_re[3*DW +: DW];
    s_im = cap_im[3*DW +: DW];
    chk("t2_slot3_re", FW'(s_re), FW'(16'h0300));
    chk("t2_slot3_im", FW'(s_im), FW'(16'hFD00));
`endif
  endtask

  logic t3_done;
  int   pos;
  logic rlast;

  initial begin
    rst_n = 1'b0;
    ordy_mode = 0;
    rnd_bit = 1'b0;
    bus_if.in_valid = 1'b0;
    bus_if.in_re = '0;
    bus_if.in_im = '0;
    bus_if.in_last = 1'b0;
    t3_done = 1'b0;

    // T1 reset and idle
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t1_in_ready",  FW'(bus_if.in_ready),  FW'(1'b1));
    chk("t1_out_valid", FW'(bus_if.out_valid), FW'(1'b0));
    chk("t1_frame_cnt", FW'(bus_if.frame_cnt), FW'(16'd0));
    chk("t1_frame_err", FW'(bus_if.frame_err), FW'(1'b0));
    chk("t1_out_re", bus_if.out_re, '0);
    @(posedge clk); #1;

    // T2 single frame
    ordy_mode = 1;
    single_frame();
    @(posedge clk); #1;

    // T3 backpressure: 24 samples into a stalled output
    ordy_mode = 0;
    fork
      begin
        for (int k = 0; k < 24; k++) send(16'($urandom), 16'($urandom), (k % 8) == 7);
        t3_done = 1'b1;
      end
    join_none
    repeat (22) @(negedge clk);
    chk("t3_stall", FW'(bus_if.in_ready), FW'(1'b0));
    @(posedge clk); #1 ordy_mode = 1;
    @(posedge clk); #1 ordy_mode = 0;
    @(negedge clk);
    chk("t3_ready_after", FW'(bus_if.in_ready),  FW'(1'b1));
    chk("t3_next_frame",  FW'(bus_if.out_valid), FW'(1'b1));
    @(posedge clk); #1 ordy_mode = 1;
    for (int i = 0; i < 200 && !t3_done; i++) @(posedge clk);
    chk("t3_finish", FW'(t3_done), FW'(1'b1));
    #1;
    repeat (4) @(posedge clk);
    #1;

    // T4 early in_last on 5th sample, then a clean frame
    for (int k = 0; k < 5; k++) send(16'(16'h1000 + k), 16'(16'h2000 + k), k == 4);
    for (int k = 0; k < 8; k++) send(16'(16'h3000 + k), 16'(16'h4000 + k), k == 7);
    repeat (4) @(posedge clk); #1;

    // T5 missing in_last
    for (int k = 0; k < 8; k++) send(16'(16'h5000 + k), 16'(16'h6000 + k), 1'b0);
    repeat (4) @(posedge clk); #1;

    // T6 reset mid-frame
    ordy_mode = 0;
    for (int k = 0; k < 12; k++) send(16'($urandom), 16'($urandom), (k % 8) == 7);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_out_valid", FW'(bus_if.out_valid), FW'(1'b0));
    chk("t6_out_re", bus_if.out_re, '0);
    @(posedge clk); #1;
    ordy_mode = 1;
    single_frame();
    @(posedge clk); #1;

    // Randomized streaming with gaps, random backpressure and framing errors
    ordy_mode = 2;
    pos = 0;
    for (int n = 0; n < 400; n++) begin
      rlast = (pos == 7);
      if ($urandom_range(0, 19) == 0) rlast = !rlast;
      send(16'($urandom), 16'($urandom), rlast);
      if (rlast || pos == 7) pos = 0; else pos++;
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    ordy_mode = 1;
    repeat (20) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
